// File: rtl/stoch_im2col_sequencer.sv
// Frame sequencer for the stochastic signed im2col datapath: one patch descriptor per beat.
// Optional stall counter output enabled by STOCH_IM2COL_SEQ_PERF_EN.
module stoch_im2col_sequencer #(
    parameter int IM_HEIGHT  = 12,
    parameter int IM_WIDTH   = 12,
    parameter int KERNEL_H   = 3,
    parameter int KERNEL_W   = 3,
    parameter int PAD_H      = 2,
    parameter int PAD_W      = 2,
    parameter int STRIDE_H   = 1,
    parameter int STRIDE_W   = 1,
    parameter int STREAM_LEN = 256,
    localparam int OUT_H      = (IM_HEIGHT + 2*PAD_H - KERNEL_H) / STRIDE_H + 1,
    localparam int OUT_W      = (IM_WIDTH + 2*PAD_W - KERNEL_W) / STRIDE_W + 1,
    localparam int COL_HEIGHT = OUT_H * OUT_W,
    localparam int NTAP       = KERNEL_H * KERNEL_W,
    localparam int RW         = $clog2(IM_HEIGHT + PAD_H) + 1,
    localparam int CW         = $clog2(IM_WIDTH + PAD_W) + 1,
    localparam int RIW        = (COL_HEIGHT > 1) ? $clog2(COL_HEIGHT) : 1,
    localparam int BW         = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [RW-1:0] win_row,
    output logic signed [CW-1:0] win_col,
    output logic [RIW-1:0]       row_idx,
    output logic [NTAP-1:0]      tap_mask,
    output logic [BW-1:0]        bit_idx,
    output logic                 last_row,
    output logic                 last_bit
`ifdef STOCH_IM2COL_SEQ_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int XW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int YW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [XW-1:0]        ox_q, nx;
    logic [YW-1:0]        oy_q, ny;
    logic [BW-1:0]        bit_q, nb;
    logic                 fire, load;
    logic signed [RW-1:0] nwr;
    logic signed [CW-1:0] nwc;
    logic [NTAP-1:0]      nmask;
    logic [RIW-1:0]       nrow;
    int                   wr, wc;

    // Next-position counters and the descriptor derived from them; outside RUN they point at the origin.
    always_comb begin
        fire = out_valid && out_ready;
        nx   = ox_q;
        ny   = oy_q;
        nb   = bit_q;
        if (state != RUN) begin
            nx = '0;
            ny = '0;
            nb = '0;
        end else if (fire) begin
            if (ox_q == XW'(OUT_W - 1)) begin
                nx = '0;
                if (oy_q == YW'(OUT_H - 1)) begin
                    ny = '0;
                    nb = bit_q + 1'b1;
                end else begin
                    ny = oy_q + 1'b1;
                end
            end else begin
                nx = ox_q + 1'b1;
            end
        end
        wr    = int'(ny) * STRIDE_H - PAD_H;
        wc    = int'(nx) * STRIDE_W - PAD_W;
        nwr   = RW'(wr);
        nwc   = CW'(wc);
        nrow  = RIW'(int'(nx) + int'(ny) * OUT_W);
        nmask = '0;
        for (int unsigned kr = 0; kr < KERNEL_H; kr++) begin
            for (int unsigned kc = 0; kc < KERNEL_W; kc++) begin
                if ((wr + int'(kr) >= 0) && (wr + int'(kr) < IM_HEIGHT) &&
                    (wc + int'(kc) >= 0) && (wc + int'(kc) < IM_WIDTH))
                    nmask = nmask | (NTAP'(1) << (kc + kr * KERNEL_W));
            end
        end
        load = ((state == IDLE) && start) ||
               ((state == RUN) && fire && !(last_row && last_bit));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
            bit_q     <= '0;
            win_row   <= '0;
            win_col   <= '0;
            row_idx   <= '0;
            tap_mask  <= '0;
            bit_idx   <= '0;
            last_row  <= 1'b0;
            last_bit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (fire && last_row && last_bit) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (load) begin
                ox_q     <= nx;
                oy_q     <= ny;
                bit_q    <= nb;
                win_row  <= nwr;
                win_col  <= nwc;
                row_idx  <= nrow;
                tap_mask <= nmask;
                bit_idx  <= nb;
                last_row <= (nrow == RIW'(COL_HEIGHT - 1));
                last_bit <= (nb == BW'(STREAM_LEN - 1));
            end
        end
    end

`ifdef STOCH_IM2COL_SEQ_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST)
            stall_cnt <= '0;
        else if ((state == IDLE) && start)
            stall_cnt <= '0;
        else if ((state == RUN) && out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_stoch_im2col_sequencer.sv
// Self-checking bench for stoch_im2col_sequencer at default parameters against a beat-index model.
// Checks stall_cnt when STOCH_IM2COL_SEQ_PERF_EN is defined.
module tb_stoch_im2col_sequencer;

    localparam int IH = 12, IW = 12, KH = 3, KW = 3, PH = 2, PW = 2, SH = 1, SW = 1;
    localparam int SL = 256;
    localparam int OH = (IH + 2*PH - KH) / SH + 1;
    localparam int OW = (IW + 2*PW - KW) / SW + 1;
    localparam int COL = OH * OW;
    localparam int TOTAL = COL * SL;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy, done, out_valid, last_row, last_bit;
    logic signed [4:0] win_row, win_col;
    logic [7:0]  row_idx, bit_idx;
    logic [8:0]  tap_mask;
    logic [36:0] desc;
`ifdef STOCH_IM2COL_SEQ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    stoch_im2col_sequencer dut (
        .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .win_row(win_row), .win_col(win_col), .row_idx(row_idx), .tap_mask(tap_mask),
        .bit_idx(bit_idx), .last_row(last_row), .last_bit(last_bit)
`ifdef STOCH_IM2COL_SEQ_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    assign desc = {win_row, win_col, row_idx, tap_mask, bit_idx, last_row, last_bit};

    // Descriptor expected for the n-th beat of a frame.
    function automatic logic [36:0] exp_desc(int n);
        int b, r, oy, ox, wr, wc;
        logic [8:0] m;
        b  = n / COL;
        r  = n % COL;
        oy = r / OW;
        ox = r % OW;
        wr = oy * SH - PH;
        wc = ox * SW - PW;
        m  = '0;
        for (int kr = 0; kr < KH; kr++)
            for (int kc = 0; kc < KW; kc++)
                if (wr + kr >= 0 && wr + kr < IH && wc + kc >= 0 && wc + kc < IW)
                    m = m | (9'd1 << (kr * KW + kc));
        return {wr[4:0], wc[4:0], r[7:0], m, b[7:0], (r == COL - 1), (b == SL - 1)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        tests++;
        if ({busy, done, out_valid} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl got busy/done/valid=%b want 000", {busy, done, out_valid});
        end
        tests++;
        if (desc !== 37'd0) begin
            fails++;
            $display("FAIL reset_desc got %h want 0", desc);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        int beat = 0;
        int cyc = 0;
        int dones = 0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (beat < TOTAL && cyc < TOTAL + 100) begin
            start = (beat == 500 || beat == 30000);
            if (done) dones++;
            tests++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                fails++;
                $display("FAIL frame_valid beat %0d got valid=%b busy=%b want 1 1", beat, out_valid, busy);
            end
            tests++;
            if (desc !== exp_desc(beat)) begin
                fails++;
                $display("FAIL frame_desc beat %0d got %h want %h", beat, desc, exp_desc(beat));
            end
            if (beat == 0 || beat == 1 || beat == 15 || beat == 30 || beat == 195 || beat == 196) begin
                logic signed [4:0] er, ec;
                logic [8:0] em;
                logic [7:0] eri, ebi;
                case (beat)
                    0:   begin er = -2; ec = -2; em = 9'h100; eri = 8'd0;   ebi = 8'd0; end
                    1:   begin er = -2; ec = -1; em = 9'h180; eri = 8'd1;   ebi = 8'd0; end
                    15:  begin er = -1; ec = -1; em = 9'h1B0; eri = 8'd15;  ebi = 8'd0; end
                    30:  begin er = 0;  ec = 0;  em = 9'h1FF; eri = 8'd30;  ebi = 8'd0; end
                    195: begin er = 11; ec = 11; em = 9'h001; eri = 8'd195; ebi = 8'd0; end
                    default: begin er = -2; ec = -2; em = 9'h100; eri = 8'd0; ebi = 8'd1; end
                endcase
                tests++;
                if ({win_row, win_col, tap_mask, row_idx, bit_idx, last_row} !==
                    {er, ec, em, eri, ebi, (beat == 195)}) begin
                    fails++;
                    $display("FAIL spot beat %0d got win=(%0d,%0d) mask=%h row=%0d bit=%0d lr=%b want (%0d,%0d) %h %0d %0d %b",
                             beat, win_row, win_col, tap_mask, row_idx, bit_idx, last_row,
                             er, ec, em, eri, ebi, (beat == 195));
                end
            end
            if (beat == TOTAL - 1) begin
                tests++;
                if ({last_row, last_bit} !== 2'b11) begin
                    fails++;
                    $display("FAIL final_flags got %b want 11", {last_row, last_bit});
                end
            end
            if (out_valid && out_ready) beat++;
            tick();
            cyc++;
        end
        start = 1'b0;
        tests++;
        if (beat != TOTAL) begin
            fails++;
            $display("FAIL frame_beats got %0d want %0d", beat, TOTAL);
        end
        if (done) dones++;
        tests++;
        if ({done, busy, out_valid} !== 3'b100) begin
            fails++;
            $display("FAIL done_state got done/busy/valid=%b want 100", {done, busy, out_valid});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        if (done) dones++;
        tests++;
        if ({done, busy, out_valid} !== 3'b000) begin
            fails++;
            $display("FAIL after_done got done/busy/valid=%b want 000", {done, busy, out_valid});
        end
        tick();
        if (done) dones++;
        tests++;
        if ({busy, out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL idle_after_done got busy/valid=%b want 00", {busy, out_valid});
        end
        tests++;
        if (dones != 1) begin
            fails++;
            $display("FAIL done_pulses got %0d want 1", dones);
        end
`ifdef STOCH_IM2COL_SEQ_PERF_EN
        tests++;
        if (stall_cnt !== 32'd0) begin
            fails++;
            $display("FAIL stall_cnt_ready1 got %0d want 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_random_ready();
        int beat = 0;
        int cyc = 0;
        int stalls = 0;
        logic [36:0] prev = '0;
        logic prev_stall = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (beat < 2000 && cyc < 20000) begin
            tests++;
            if (out_valid !== 1'b1 || desc !== exp_desc(beat)) begin
                fails++;
                $display("FAIL rand_desc beat %0d got valid=%b %h want 1 %h", beat, out_valid, desc, exp_desc(beat));
            end
            if (prev_stall) begin
                tests++;
                if (desc !== prev) begin
                    fails++;
                    $display("FAIL stall_hold beat %0d got %h want %h", beat, desc, prev);
                end
            end
            out_ready = ($urandom_range(0, 99) < 30);
            prev = desc;
            prev_stall = !out_ready;
            if (!out_ready) stalls++;
            if (out_ready) beat++;
            tick();
            cyc++;
        end
        tests++;
        if (beat != 2000) begin
            fails++;
            $display("FAIL rand_beats got %0d want 2000", beat);
        end
`ifdef STOCH_IM2COL_SEQ_PERF_EN
        tests++;
        if (stall_cnt !== 32'(stalls)) begin
            fails++;
            $display("FAIL stall_cnt got %0d want %0d", stall_cnt, stalls);
        end
`endif
        out_ready = 1'b1;
        RST = 1'b1;
        tick();
        RST = 1'b0;
`ifdef STOCH_IM2COL_SEQ_PERF_EN
        tests++;
        if (stall_cnt !== 32'd0) begin
            fails++;
            $display("FAIL stall_cnt_rst got %0d want 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_rst_mid_run();
        int beat = 0;
        int cyc = 0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (beat < 1000 && cyc < 1100) begin
            if (out_valid && out_ready) beat++;
            tick();
            cyc++;
        end
        tests++;
        if (desc !== exp_desc(1000)) begin
            fails++;
            $display("FAIL pre_rst_desc got %h want %h", desc, exp_desc(1000));
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tests++;
        if ({out_valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL mid_rst got valid/busy/done=%b want 000", {out_valid, busy, done});
        end
        tick();
        tests++;
        if ({out_valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL post_rst_idle got valid/busy/done=%b want 000", {out_valid, busy, done});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || row_idx !== 8'd0 || bit_idx !== 8'd0 || desc !== exp_desc(0)) begin
            fails++;
            $display("FAIL restart got valid=%b row=%0d bit=%0d %h want 1 0 0 %h",
                     out_valid, row_idx, bit_idx, desc, exp_desc(0));
        end
        tick();
        tests++;
        if (desc !== exp_desc(1)) begin
            fails++;
            $display("FAIL restart_beat1 got %h want %h", desc, exp_desc(1));
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_ready();
        test_rst_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
